// File: rtl/wb_retire_queue.sv
// Writeback retire queue: circular FIFO between memory stage and register-file
// write/fetch redirect, with control-flow and SYSTEM-op stall detection.
module wb_retire_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int ILEN  = 32
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       IN_V,
    output logic                       IN_READY,
    input  logic [ILEN-1:0]            IN_IR,
    input  logic [XLEN-1:0]            IN_RES,
    input  logic                       IN_REG_WEN,
    input  logic                       IN_W,
    input  logic                       IN_PC_MUX,
    input  logic [XLEN-1:0]            IN_TARGET,
    input  logic                       RETIRE_EN,
    output logic                       OUT_DE_REG_WEN,
    output logic [4:0]                 OUT_DE_DR,
    output logic [XLEN-1:0]            OUT_DE_Data,
    output logic                       OUT_FE_PC_MUX,
    output logic [XLEN-1:0]            OUT_FE_Target_Address,
    output logic                       V_OUT_FE_BR_STALL,
    output logic                       V_WB_FE_TRAP_STALL,
    output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY,
    output logic [31:0]                RETIRED_CNT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [ILEN-1:0]  ir_q  [DEPTH];
    logic [XLEN-1:0]  res_q [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];
    logic [DEPTH-1:0] wen_q;
    logic [DEPTH-1:0] w_q;
    logic [DEPTH-1:0] pcm_q;
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;
    logic [31:0]      cnt;

    logic             empty;
    logic             enq;
    logic             fire;
    logic             flush;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_data;
    logic             br_pending;
    logic             trap_pending;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // JAL, JALR and conditional branches all live in opcode[6:2]
    function automatic logic is_ctrl(input logic [4:0] op);
        return (op == 5'b11000) || (op == 5'b11001) || (op == 5'b11011);
    endfunction

    assign empty    = (occ == '0);
    assign IN_READY = (occ < OW'(DEPTH));
    assign enq      = IN_V && IN_READY;
    assign fire     = !empty && RETIRE_EN;
    assign flush    = fire && pcm_q[rd_ptr];
    assign head_rd  = ir_q[rd_ptr][11:7];

    always_comb begin
        head_data = res_q[rd_ptr];
        if (w_q[rd_ptr]) begin
            head_data       = {XLEN{res_q[rd_ptr][31]}};
            head_data[31:0] = res_q[rd_ptr][31:0];
        end
    end

    // The incoming instruction counts for the branch stall so fetch holds off a cycle earlier
    always_comb begin
        br_pending   = IN_V && is_ctrl(IN_IR[6:2]);
        trap_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                br_pending   = br_pending | is_ctrl(ir_q[i][6:2]);
                trap_pending = trap_pending | (ir_q[i][6:0] == 7'b1110011);
            end
        end
    end

    assign OUT_DE_REG_WEN        = fire && wen_q[rd_ptr] && (head_rd != 5'd0);
    assign OUT_DE_DR             = head_rd;
    assign OUT_DE_Data           = head_data;
    assign OUT_FE_PC_MUX         = flush;
    assign OUT_FE_Target_Address = empty ? '0 : tgt_q[rd_ptr];
    assign V_OUT_FE_BR_STALL     = br_pending;
    assign V_WB_FE_TRAP_STALL    = trap_pending;
    assign OCCUPANCY             = occ;
    assign RETIRED_CNT           = cnt;

    // A redirecting retire squashes everything younger, including a same-cycle enqueue
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            vld_q  <= '0;
            wen_q  <= '0;
            w_q    <= '0;
            pcm_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ir_q[i]  <= '0;
                res_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            if (fire) begin
                cnt <= cnt + 32'd1;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
                vld_q  <= '0;
            end else begin
                if (fire) begin
                    vld_q[rd_ptr] <= 1'b0;
                    rd_ptr        <= next_ptr(rd_ptr);
                end
                if (enq) begin
                    ir_q[wr_ptr]  <= IN_IR;
                    res_q[wr_ptr] <= IN_RES;
                    tgt_q[wr_ptr] <= IN_TARGET;
                    wen_q[wr_ptr] <= IN_REG_WEN;
                    w_q[wr_ptr]   <= IN_W;
                    pcm_q[wr_ptr] <= IN_PC_MUX;
                    vld_q[wr_ptr] <= 1'b1;
                    wr_ptr        <= next_ptr(wr_ptr);
                end
                if (enq && !fire) begin
                    occ <= occ + OW'(1);
                end else if (!enq && fire) begin
                    occ <= occ - OW'(1);
                end
            end
        end
    end

endmodule
